multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for the multicycle CPU datapath. It decodes the latched instruction
//  (IReg_out) and the datapath Branch flag, and drives every datapath control line.
//  It sequences FETCH/DECODE/EXEC/MEM/WB one state per clk.
//  Top level: pairs 1:1 with datapath; this block is the only source of its controls.
// PARAMETERS
//  OPW      6   opcode width, IReg_out[31:26]
//  STATE_W  4   width of debug state output
// PORTS
//  clk         in   1   system clock, all state updates on posedge
//  reset       in   1   asynchronous, active-high; FSM -> FETCH immediately
//  IReg_out    in   32  instruction register contents from datapath
//  Branch      in   1   datapath branch-taken flag (valid in BRANCH state)
//  PCWrite     out  1   PC load enable
//  MemRead     out  1   data memory read strobe
//  MemWrite    out  1   data memory write enable
//  IRWrite     out  1   instruction register load enable
//  MemtoReg    out  1   0: write ALUOut, 1: write MDR
//  PCSource    out  2   00 ALU wire, 01 ALUOut, 10 jump, 11 branch
//  ALUOp       out  4   0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOR,6 SLL,7 SRL,8 PASSB
//  ALUSrcB     out  2   00 regB, 01 const 1, 10 SE(imm), 11 ZE(imm)
//  ALUSrcA     out  1   0 PC, 1 regA
//  RegWrite    out  1   register file write enable
//  BranchType  out  1   0 BEQ, 1 BNE
//  LUI         out  1   register file upper-half write
//  SWB         out  1   readsel swap for SW/BEQ/BNE
//  instr_done  out  1   1-cycle pulse in final state of each instruction
//  illegal     out  1   sticky illegal-opcode flag (see CONFIGURATION)
//  state       out  4   current FSM state (debug)
// BEHAVIOUR
//  Opcodes: 00 NOP; 01-09 R-type, ALUOp=op-1, r1<=r2 op r3; 11-19 I-type, ALUOp=op-0x11,
//   SrcB=SE for ALUOp 0/1 and ZE otherwise; 20 LW r1<=M[imm]; 21 SW M[imm]<=r1;
//   22 LUI; 30 J; 31 BEQ; 32 BNE. All other opcodes are illegal.
//  States: FETCH=0 DECODE=1 EXEC=2 ALU_WB=3 MEM_RD=4 MEM_WB=5 MEM_WR=6 LUI_WB=7
//   JUMP=8 BRANCH=9 HALT=15. Moore outputs; any unlisted control is 0.
//  FETCH: IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00, PCWrite=1 -> DECODE.
//  DECODE: regA/regB latch; next state is EXEC for R/I-type or LUI, MEM_RD for LW,
//   MEM_WR for SW, JUMP for J, BRANCH for BEQ/BNE, FETCH for NOP or illegal.
//  EXEC: ALUSrcA=1, ALUSrcB/ALUOp per opcode (LUI: SrcB=11, ALUOp=PASSB) -> ALU_WB | LUI_WB.
//  ALU_WB: RegWrite=1, MemtoReg=0. LUI_WB: same plus LUI=1. MEM_RD: MemRead=1 -> MEM_WB.
//  MEM_WB: MemRead=1, MemtoReg=1, RegWrite=1. MEM_WR: MemWrite=1.
//  JUMP: PCSource=10, PCWrite=1. BRANCH: BranchType=op[0]^1 (BEQ 0, BNE 1), PCWrite=Branch.
//  States ALU_WB, LUI_WB, MEM_WB, MEM_WR, JUMP and BRANCH return to FETCH with instr_done=1.
//  DECODE also returns to FETCH with instr_done=1 for NOP.
//  SWB=1 in every state except FETCH when opcode is 21/31/32; SWB=0 in FETCH.
//  Latency in cycles: NOP 2; J/BEQ/BNE/SW 3; LW/LUI/R/I 4.
//  Reset: while reset is high, every output is 0 except state=FETCH.
//   FETCH outputs resume on the first posedge after reset deasserts.
//  Reset mid-instruction abandons it with no partial write; the next cycle is FETCH.
//  Opcode is sampled from IReg_out each state; IRWrite is asserted only in FETCH,
//   so the opcode is stable across the instruction.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: illegal opcode in DECODE -> HALT; illegal=1 sticky.
//   HALT drives all enables 0 and stays until reset; no instr_done.
//  Undefined: illegal opcode is executed as NOP (DECODE -> FETCH, instr_done=1).
//   In this case illegal is tied to 0.
// TESTING
//  reset pulse mid-MEM_WR -> MemWrite drops async, state=0; next posedge FETCH, IRWrite=1
//  IReg=0x04221800 (ADD r1,r2,r3) -> states 0,1,2,3; EXEC ALUOp=0, SrcB=00; WB RegWrite=1
//  LW op 20 -> 0,1,4,5; MEM_WB MemtoReg=1, RegWrite=1; SW op 21 -> MEM_WR MemWrite=1, SWB=1
//  BEQ op 31: Branch=1 -> PCWrite=1, BranchType=0; BNE Branch=0 -> PCWrite=0, BranchType=1
//  J op 30 -> JUMP PCSource=10, PCWrite=1; instr_done pulses exactly once per instruction
//  opcode 0x3F: TRAP_EN -> state=15, illegal=1 until reset; else 2-cycle NOP, illegal=0

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between multicycle_controller (master) and the datapath (slave).
// Carries the instruction/branch feedback and every datapath control line.
interface multicycle_controller_if #(
  parameter int STATE_W = 4
);
  logic [31:0]        IReg_out;
  logic               Branch;
  logic               PCWrite;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic [1:0]         PCSource;
  logic [3:0]         ALUOp;
  logic [1:0]         ALUSrcB;
  logic               ALUSrcA;
  logic               RegWrite;
  logic               BranchType;
  logic               LUI;
  logic               SWB;
  logic               instr_done;
  logic               illegal;
  logic [STATE_W-1:0] state;

  modport master (
    input  IReg_out, Branch,
    output PCWrite, MemRead, MemWrite, IRWrite, MemtoReg, PCSource, ALUOp,
           ALUSrcB, ALUSrcA, RegWrite, BranchType, LUI, SWB, instr_done,
           illegal, state
  );

  modport slave (
    output IReg_out, Branch,
    input  PCWrite, MemRead, MemWrite, IRWrite, MemtoReg, PCSource, ALUOp,
           ALUSrcB, ALUSrcA, RegWrite, BranchType, LUI, SWB, instr_done,
           illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB, Moore-style controls.
// Define ILLEGAL_TRAP_EN to trap illegal opcodes into a sticky HALT state.
module multicycle_controller #(
  parameter int OPW     = 6,
  parameter int STATE_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC   = 4'd2,
    ALU_WB = 4'd3,
    MEM_RD = 4'd4,
    MEM_WB = 4'd5,
    MEM_WR = 4'd6,
    LUI_WB = 4'd7,
    JUMP   = 4'd8,
    BRANCH = 4'd9,
    HALT   = 4'd15
  } state_e;

  localparam logic [OPW-1:0] OP_NOP = OPW'(6'h00);
  localparam logic [OPW-1:0] OP_LW  = OPW'(6'h20);
  localparam logic [OPW-1:0] OP_SW  = OPW'(6'h21);
  localparam logic [OPW-1:0] OP_LUI = OPW'(6'h22);
  localparam logic [OPW-1:0] OP_J   = OPW'(6'h30);
  localparam logic [OPW-1:0] OP_BEQ = OPW'(6'h31);
  localparam logic [OPW-1:0] OP_BNE = OPW'(6'h32);

  state_e state_q, state_d;
  logic   run_q, run_d;

`ifdef ILLEGAL_TRAP_EN
  logic   illegal_q, illegal_d;
`endif

  logic [OPW-1:0] op_s;
  logic           is_r_s, is_i_s, is_branch_s, swb_op_s;
  logic [3:0]     alu_op_s;
  logic           ireg_unused_s;

  logic       pc_write_s, mem_read_s, mem_write_s, ir_write_s, mem_to_reg_s;
  logic [1:0] pc_source_s, alu_src_b_s;
  logic [3:0] alu_op_out_s;
  logic       alu_src_a_s, reg_write_s, branch_type_s, lui_s, swb_s, done_s;

  assign op_s          = bus.IReg_out[31 -: OPW];
  assign ireg_unused_s = ^bus.IReg_out[31-OPW:0];

  // Opcode classification; R- and I-type share low-nibble minus one as ALUOp.
  always_comb begin
    is_r_s      = (op_s >= OPW'(6'h01)) && (op_s <= OPW'(6'h09));
    is_i_s      = (op_s >= OPW'(6'h11)) && (op_s <= OPW'(6'h19));
    is_branch_s = (op_s == OP_BEQ) || (op_s == OP_BNE);
    swb_op_s    = (op_s == OP_SW) || is_branch_s;
    alu_op_s    = op_s[3:0] - 4'd1;
  end

  // Next-state and Moore control decode; everything is held at 0 until run_q.
  always_comb begin
    state_d       = state_q;
    run_d         = 1'b1;
`ifdef ILLEGAL_TRAP_EN
    illegal_d     = illegal_q;
`endif
    pc_write_s    = 1'b0;
    mem_read_s    = 1'b0;
    mem_write_s   = 1'b0;
    ir_write_s    = 1'b0;
    mem_to_reg_s  = 1'b0;
    pc_source_s   = 2'b00;
    alu_op_out_s  = 4'd0;
    alu_src_b_s   = 2'b00;
    alu_src_a_s   = 1'b0;
    reg_write_s   = 1'b0;
    branch_type_s = 1'b0;
    lui_s         = 1'b0;
    swb_s         = 1'b0;
    done_s        = 1'b0;

    if (!run_q) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          ir_write_s  = 1'b1;
          alu_src_b_s = 2'b01;
          pc_write_s  = 1'b1;
          state_d     = DECODE;
        end
        DECODE: begin
          if (is_r_s || is_i_s || (op_s == OP_LUI)) begin
            state_d = EXEC;
          end else if (op_s == OP_LW) begin
            state_d = MEM_RD;
          end else if (op_s == OP_SW) begin
            state_d = MEM_WR;
          end else if (op_s == OP_J) begin
            state_d = JUMP;
          end else if (is_branch_s) begin
            state_d = BRANCH;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            if (op_s == OP_NOP) begin
              state_d = FETCH;
              done_s  = 1'b1;
            end else begin
              state_d   = HALT;
              illegal_d = 1'b1;
            end
`else
            state_d = FETCH;
            done_s  = 1'b1;
`endif
          end
        end
        EXEC: begin
          alu_src_a_s = 1'b1;
          if (op_s == OP_LUI) begin
            alu_src_b_s  = 2'b11;
            alu_op_out_s = 4'd8;
            state_d      = LUI_WB;
          end else begin
            alu_op_out_s = alu_op_s;
            if (is_r_s) begin
              alu_src_b_s = 2'b00;
            end else if (alu_op_s < 4'd2) begin
              alu_src_b_s = 2'b10;
            end else begin
              alu_src_b_s = 2'b11;
            end
            state_d = ALU_WB;
          end
        end
        ALU_WB: begin
          reg_write_s = 1'b1;
          done_s      = 1'b1;
          state_d     = FETCH;
        end
        LUI_WB: begin
          reg_write_s = 1'b1;
          lui_s       = 1'b1;
          done_s      = 1'b1;
          state_d     = FETCH;
        end
        MEM_RD: begin
          mem_read_s = 1'b1;
          state_d    = MEM_WB;
        end
        MEM_WB: begin
          mem_read_s   = 1'b1;
          mem_to_reg_s = 1'b1;
          reg_write_s  = 1'b1;
          done_s       = 1'b1;
          state_d      = FETCH;
        end
        MEM_WR: begin
          mem_write_s = 1'b1;
          done_s      = 1'b1;
          state_d     = FETCH;
        end
        JUMP: begin
          pc_source_s = 2'b10;
          pc_write_s  = 1'b1;
          done_s      = 1'b1;
          state_d     = FETCH;
        end
        BRANCH: begin
          branch_type_s = ~op_s[0];
          pc_write_s    = bus.Branch;
          done_s        = 1'b1;
          state_d       = FETCH;
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
      if (state_q != FETCH) begin
        swb_s = swb_op_s;
      end else begin
        swb_s = 1'b0;
      end
    end
  end

  // State register; run_q holds off FETCH outputs until the first edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.PCWrite    = pc_write_s;
  assign bus.MemRead    = mem_read_s;
  assign bus.MemWrite   = mem_write_s;
  assign bus.IRWrite    = ir_write_s;
  assign bus.MemtoReg   = mem_to_reg_s;
  assign bus.PCSource   = pc_source_s;
  assign bus.ALUOp      = alu_op_out_s;
  assign bus.ALUSrcB    = alu_src_b_s;
  assign bus.ALUSrcA    = alu_src_a_s;
  assign bus.RegWrite   = reg_write_s;
  assign bus.BranchType = branch_type_s;
  assign bus.LUI        = lui_s;
  assign bus.SWB        = swb_s;
  assign bus.instr_done = done_s;
  assign bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-stream bench for multicycle_controller against a
// per-opcode state-sequence reference model.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic [1:0] alu_src_b;
    logic       alu_src_a;
    logic       reg_write;
    logic       branch_type;
    logic       lui;
    logic       swb;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;
  } ctrl_t;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  multicycle_controller_if bus();
  multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ctrl_t sample();
    ctrl_t a;
    a.pc_write    = bus.PCWrite;
    a.mem_read    = bus.MemRead;
    a.mem_write   = bus.MemWrite;
    a.ir_write    = bus.IRWrite;
    a.mem_to_reg  = bus.MemtoReg;
    a.pc_source   = bus.PCSource;
    a.alu_op      = bus.ALUOp;
    a.alu_src_b   = bus.ALUSrcB;
    a.alu_src_a   = bus.ALUSrcA;
    a.reg_write   = bus.RegWrite;
    a.branch_type = bus.BranchType;
    a.lui         = bus.LUI;
    a.swb         = bus.SWB;
    a.instr_done  = bus.instr_done;
    a.illegal     = bus.illegal;
    a.state       = bus.state;
    return a;
  endfunction

  function automatic bit is_r(input logic [5:0] op);
    return (op >= 6'd1) && (op <= 6'd9);
  endfunction

  function automatic bit is_i(input logic [5:0] op);
    return (op >= 6'h11) && (op <= 6'h19);
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'h00) || is_r(op) || is_i(op) || (op == 6'h20) || (op == 6'h21) ||
           (op == 6'h22) || (op == 6'h30) || (op == 6'h31) || (op == 6'h32);
  endfunction

  function automatic bit halts(input logic [5:0] op);
    return TRAP && !is_legal(op);
  endfunction

  // Cycles observed per instruction; trapped opcodes are watched for 3 HALT cycles.
  function automatic int seq_len(input logic [5:0] op);
    if (op == 6'h00) return 2;
    if (!is_legal(op)) return halts(op) ? 5 : 2;
    if (is_r(op) || is_i(op) || op == 6'h22 || op == 6'h20) return 4;
    return 3;
  endfunction

  function automatic int state_at(input logic [5:0] op, input int step);
    if (step == 0) return 0;
    if (step == 1) return 1;
    if (!is_legal(op)) return 15;
    if (is_r(op) || is_i(op)) return (step == 2) ? 2 : 3;
    if (op == 6'h22) return (step == 2) ? 2 : 7;
    if (op == 6'h20) return (step == 2) ? 4 : 5;
    if (op == 6'h21) return 6;
    if (op == 6'h30) return 8;
    return 9;
  endfunction

  function automatic ctrl_t model(input logic [5:0] op, input int step, input logic br);
    ctrl_t e;
    int    st;
    int    aop;
    e  = '0;
    st = state_at(op, step);
    e.state = 4'(st);
    case (st)
      0:  begin e.ir_write = 1'b1; e.alu_src_b = 2'b01; e.pc_write = 1'b1; end
      1:  e.instr_done = (op == 6'h00) || (!is_legal(op) && !TRAP);
      2:  begin
            e.alu_src_a = 1'b1;
            if (op == 6'h22) begin
              e.alu_src_b = 2'b11; e.alu_op = 4'd8;
            end else if (is_r(op)) begin
              e.alu_op = 4'(int'(op) - 1);
            end else begin
              aop = int'(op) - 'h11;
              e.alu_op    = 4'(aop);
              e.alu_src_b = (aop <= 1) ? 2'b10 : 2'b11;
            end
          end
      3:  begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
      4:  e.mem_read = 1'b1;
      5:  begin e.mem_read = 1'b1; e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1; end
      6:  begin e.mem_write = 1'b1; e.instr_done = 1'b1; end
      7:  begin e.reg_write = 1'b1; e.lui = 1'b1; e.instr_done = 1'b1; end
      8:  begin e.pc_source = 2'b10; e.pc_write = 1'b1; e.instr_done = 1'b1; end
      9:  begin e.branch_type = (op == 6'h32); e.pc_write = br; e.instr_done = 1'b1; end
      default: e.illegal = 1'b1;
    endcase
    if (st != 0 && (op == 6'h21 || op == 6'h31 || op == 6'h32)) e.swb = 1'b1;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1 check_eq("reset_hold", 32'(sample()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check_eq("reset_release", 32'(sample()), 32'd0);
  endtask

  // br_mode: 0/1 forces Branch, 2 randomizes it every cycle.
  task automatic run_instr(input logic [31:0] instr, input int br_mode);
    logic [5:0] op;
    int         n;
    int         dones;
    logic       br;
    ctrl_t      a;
    op    = instr[31:26];
    n     = seq_len(op);
    dones = 0;
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      if (s == 1) bus.IReg_out = instr;
      br = (br_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(br_mode);
      bus.Branch = br;
      #1;
      a = sample();
      check_eq($sformatf("op%02h_step%0d", op, s), 32'(a), 32'(model(op, s, br)));
      dones += int'(a.instr_done);
    end
    check_eq($sformatf("op%02h_done_cnt", op), 32'(dones), halts(op) ? 32'd0 : 32'd1);
    if (halts(op)) do_reset();
  endtask

  logic [5:0] legal_ops [0:14] = '{6'h00, 6'h01, 6'h04, 6'h07, 6'h09, 6'h11, 6'h12, 6'h15,
                                   6'h19, 6'h20, 6'h21, 6'h22, 6'h30, 6'h31, 6'h32};

  initial begin
    logic [5:0]  op;
    logic [31:0] sw_instr;
    bus.IReg_out = 32'd0;
    bus.Branch   = 1'b0;
    #1 check_eq("reset_init", 32'(sample()), 32'd0);
    do_reset();

    run_instr(32'h04221800, 2);
    run_instr({6'h20, 26'h0001234}, 2);
    run_instr({6'h21, 26'h0000040}, 2);
    run_instr({6'h31, 26'h0000010}, 1);
    run_instr({6'h32, 26'h0000010}, 0);
    run_instr({6'h30, 26'h0000100}, 2);
    run_instr({6'h22, 26'h000ABCD}, 2);
    run_instr({6'h11, 26'h0000FFF}, 2);
    run_instr({6'h13, 26'h0000FFF}, 2);
    run_instr({6'h09, 26'h0000000}, 2);
    run_instr(32'h00000000, 2);
    run_instr({6'h3F, 26'h3FFFFFF}, 2);

    // Reset asserted in the middle of MEM_WR must kill MemWrite immediately.
    sw_instr   = {6'h21, 26'h0000080};
    bus.Branch = 1'b0;
    @(negedge clk);
    #1 check_eq("sw_fetch", 32'(sample()), 32'(model(6'h21, 0, 1'b0)));
    @(negedge clk);
    bus.IReg_out = sw_instr;
    #1 check_eq("sw_decode", 32'(sample()), 32'(model(6'h21, 1, 1'b0)));
    @(negedge clk);
    #1 check_eq("sw_memwr", 32'(sample()), 32'(model(6'h21, 2, 1'b0)));
    reset = 1'b1;
    #1 check_eq("async_rst", 32'(sample()), 32'd0);
    reset = 1'b0;
    #1 check_eq("async_rst_rel", 32'(sample()), 32'd0);
    @(posedge clk);
    #1 check_eq("post_rst_fetch", 32'(sample()), 32'(model(6'h21, 0, 1'b0)));

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 14)];
      run_instr({op, 26'($urandom)}, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
